// File: rtl/cond_logic_pkg.sv
// cond_logic_pkg: shared definitions for the condition/flag stage.
//   - cond_e     : ARM condition-field encodings (Instr[31:28])
//   - FLAG_*     : bit positions of N, Z, C, V inside the {N,Z,C,V} vector
//   - FLAGW_*    : bit positions inside the decoder's FlagW field
package cond_logic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW[1] covers N,Z (flags[3:2]); FlagW[0] covers C,V (flags[1:0]).
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_cond_check.sv
// cond_check: pure combinational condition evaluator.
// Ports:
//   cond    in  4  instruction condition field
//   flags   in  4  {N,Z,C,V} to test against
//   cond_ex out 1  1 when the condition holds
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// cond_logic: condition/flag stage behind the ALU of a single-cycle ARM
// datapath. Holds the architectural flags, gates the decoder's write
// enables with the condition result, saves/restores flags around
// exceptions and counts condition-failed instructions (saturating).
// Ports:
//   clk, reset (async, active-low)
//   en                         instruction advance (0 = stall)
//   Cond, ALUFlags, FlagW      condition field, ALU flags, flag write mask
//   PCS, RegW, MemW, NoWrite   decoder write requests
//   exc_entry, exc_return      exception entry / return
//   CondEx                     condition passed (combinational)
//   PCSrc, RegWrite, MemWrite  gated write enables (combinational)
//   Flags, SavedFlags          registered flags / flags saved at entry
//   cond_fail_cnt              saturating condition-failed count
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             exc_entry,
  input  logic             exc_return,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [3:0]       SavedFlags,
  output logic [CNT_W-1:0] cond_fail_cnt
);

  logic [3:0]       flags_reg, flags_next;
  logic [3:0]       saved_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             exc_any;
  logic             go;
  logic             save;
  logic             restore;
  logic             count;

  // Condition is tested against the registered flags, so a flag-setting
  // instruction only affects the following instruction.
  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_reg),
    .cond_ex (CondEx)
  );

  assign exc_any = exc_entry | exc_return;
  assign go      = en & CondEx & ~exc_any;
  // Entry wins over return when both are raised.
  assign save    = en & exc_entry;
  assign restore = en & exc_return & ~exc_entry;
  assign count   = en & ~exc_any & ~CondEx;

  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & ~NoWrite & go;
  assign MemWrite = MemW & go;

  // Each FlagW bit owns one two-bit slice of the flag register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_flag_slice
    assign flags_next[2*gi+1:2*gi] =
      restore              ? saved_reg[2*gi+1:2*gi] :
      (go && FlagW[gi])    ? ALUFlags[2*gi+1:2*gi]  :
                             flags_reg[2*gi+1:2*gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_reg <= 4'b0000;
      saved_reg <= 4'b0000;
      cnt_reg   <= '0;
    end else begin
      flags_reg <= flags_next;
      if (save)
        saved_reg <= flags_reg;
      if (count && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign Flags         = flags_reg;
  assign SavedFlags    = saved_reg;
  assign cond_fail_cnt = cnt_reg;

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  Cond = 4'b1110;
  logic [3:0]  ALUFlags = 4'b0000;
  logic [1:0]  FlagW = 2'b00;
  logic        PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic        exc_entry = 1'b0, exc_return = 1'b0;

  logic        CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]  Flags, SavedFlags;
  logic [15:0] cond_fail_cnt;

  logic        s_CondEx, s_PCSrc, s_RegWrite, s_MemWrite;
  logic [3:0]  s_Flags, s_SavedFlags;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_flags, m_saved;
  int         m_fail;

  always #5 clk = ~clk;

  cond_logic #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .exc_entry(exc_entry), .exc_return(exc_return),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .SavedFlags(SavedFlags), .cond_fail_cnt(cond_fail_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  cond_logic #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .exc_entry(exc_entry), .exc_return(exc_return),
    .CondEx(s_CondEx), .PCSrc(s_PCSrc), .RegWrite(s_RegWrite), .MemWrite(s_MemWrite),
    .Flags(s_Flags), .SavedFlags(s_SavedFlags), .cond_fail_cnt(s_cnt)
  );

  // Condition semantics: odd codes are the negation of the even code below.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic int sat(input int x, input int maxv);
    return (x > maxv) ? maxv : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = 4'b0000;
    m_saved = 4'b0000;
    m_fail  = 0;
  endtask

  // Inputs are already set (at a negedge). Check combinational outputs,
  // clock one edge, update the model, then check registered state.
  task automatic cycle();
    logic ok, g;
    #1;
    ok = cond_holds(Cond, m_flags);
    g  = en && ok && !exc_entry && !exc_return;
    chk("CondEx",   {31'b0, CondEx},   {31'b0, ok});
    chk("PCSrc",    {31'b0, PCSrc},    {31'b0, PCS && g});
    chk("RegWrite", {31'b0, RegWrite}, {31'b0, RegW && !NoWrite && g});
    chk("MemWrite", {31'b0, MemWrite}, {31'b0, MemW && g});
    chk("s_RegWrite", {31'b0, s_RegWrite}, {31'b0, RegW && !NoWrite && g});
    @(posedge clk);
    if (en) begin
      if (exc_entry)       m_saved = m_flags;
      else if (exc_return) m_flags = m_saved;
      else if (ok) begin
        if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
        if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
      end else
        m_fail++;
    end
    #1;
    chk("Flags",      {28'b0, Flags},      {28'b0, m_flags});
    chk("SavedFlags", {28'b0, SavedFlags}, {28'b0, m_saved});
    chk("cnt16",      {16'b0, cond_fail_cnt}, 32'(sat(m_fail, 65535)));
    chk("cnt2",       {30'b0, s_cnt},      32'(sat(m_fail, 3)));
    chk("s_Flags",    {28'b0, s_Flags},    {28'b0, m_flags});
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                        input logic pcs_i, input logic regw_i, input logic memw_i,
                        input logic nw_i, input logic ee, input logic er, input logic en_i);
    Cond = c; ALUFlags = af; FlagW = fw; PCS = pcs_i; RegW = regw_i; MemW = memw_i;
    NoWrite = nw_i; exc_entry = ee; exc_return = er; en = en_i;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset release: AL instruction with RegW.
    set_in(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1);
    #1;
    chk("rst_RegWrite", {31'b0, RegWrite}, 32'd1);
    chk("rst_Flags", {28'b0, Flags}, 32'd0);
    chk("rst_cnt", {16'b0, cond_fail_cnt}, 32'd0);
    cycle();

    // Reset asserted mid-instruction with a pending full flag write.
    set_in(4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("midrst_Flags", {28'b0, Flags}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Flag write and one-cycle latency.
    set_in(4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0, 1); cycle();
    chk("lat_Flags", {28'b0, Flags}, 32'b0100);
    set_in(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1); #1;
    chk("lat_EQ", {31'b0, CondEx}, 32'd1);
    cycle();
    set_in(4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1); #1;
    chk("lat_NE_RegWrite", {31'b0, RegWrite}, 32'd0);
    cycle();
    chk("lat_cnt", {16'b0, cond_fail_cnt}, 32'd1);

    // Partial write and LT with NoWrite.
    set_in(4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 1); cycle();
    set_in(4'hE, 4'h0, 2'b10, 0, 0, 0, 0, 0, 0, 1); cycle();
    chk("part_Flags", {28'b0, Flags}, 32'b0011);
    set_in(4'hB, 4'h0, 2'b00, 0, 1, 1, 1, 0, 0, 1); #1;
    chk("LT_CondEx", {31'b0, CondEx}, 32'd1);
    chk("LT_MemWrite", {31'b0, MemWrite}, 32'd1);
    chk("LT_RegWrite", {31'b0, RegWrite}, 32'd0);
    cycle();

    // Stall.
    set_in(4'hE, 4'b1010, 2'b11, 1, 1, 1, 0, 0, 0, 0); #1;
    chk("stall_PCSrc", {31'b0, PCSrc}, 32'd0);
    cycle();
    chk("stall_Flags", {28'b0, Flags}, 32'b0011);

    // Exception save / restore / priority.
    set_in(4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0, 1); cycle();
    set_in(4'hE, 4'b0110, 2'b11, 1, 1, 1, 0, 1, 0, 1); cycle();
    chk("entry_Saved", {28'b0, SavedFlags}, 32'b1001);
    chk("entry_Flags", {28'b0, Flags}, 32'b1001);
    set_in(4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0, 1); cycle();
    set_in(4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 1, 1); cycle();
    chk("return_Flags", {28'b0, Flags}, 32'b1001);
    set_in(4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0, 1); cycle();
    set_in(4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 1, 1, 1); cycle();
    chk("both_Saved", {28'b0, SavedFlags}, 32'b0100);
    chk("both_Flags", {28'b0, Flags}, 32'b0100);
    set_in(4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 1, 1, 0); cycle();   // ignored when stalled

    // Saturation with NV on the 2-bit counter.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 0, 0, 1); cycle();
      chk("sat_cnt2", {30'b0, s_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) != 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
